// File: rtl/multiplexer_2_block_if.sv
// Bundle of the sample-in / result-out signals of the dual multiplexer.
// The master side drives samples and the slave side returns registered results.
interface multiplexer_2_block_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             select_line;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [1:0]       selection;
    logic [WIDTH-1:0] input_option1;
    logic [WIDTH-1:0] input_option2;
    logic [WIDTH-1:0] input_option3;
    logic [WIDTH-1:0] output_data;
    logic [WIDTH-1:0] output_result;
    logic             out_valid;
    logic             sel_error;

    modport master (
        output in_valid, select_line, input_a, input_b,
        output selection, input_option1, input_option2, input_option3,
        input  output_data, output_result, out_valid, sel_error
    );

    modport slave (
        input  in_valid, select_line, input_a, input_b,
        input  selection, input_option1, input_option2, input_option3,
        output output_data, output_result, out_valid, sel_error
    );
endinterface

// File: rtl/multiplexer_2_block.sv
// Registered 2:1 and 3:1 multiplexers sharing one valid, with 1-cycle latency.
// Define MULTIPLEXER_SEL_ERR_EN to build the sticky illegal-selection flag.
module multiplexer_2_block #(
    parameter int WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    multiplexer_2_block_if.slave io
);
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             vld_q;

    always_comb begin
        data_d   = io.select_line ? io.input_b : io.input_a;
        result_d = '0;
        case (io.selection)
            2'd0:    result_d = io.input_option1;
            2'd1:    result_d = io.input_option2;
            2'd2:    result_d = io.input_option3;
            default: result_d = '0;
        endcase
    end

    // Both channels load together only on accepted samples; otherwise they hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            result_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= io.in_valid;
            if (io.in_valid) begin
                data_q   <= data_d;
                result_q <= result_d;
            end
        end
    end

`ifdef MULTIPLEXER_SEL_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (io.in_valid && (io.selection == 2'd3)) begin
            err_q <= 1'b1;
        end
    end

    assign io.sel_error = err_q;
`else
    assign io.sel_error = 1'b0;
`endif

    assign io.output_data   = data_q;
    assign io.output_result = result_q;
    assign io.out_valid     = vld_q;
endmodule

// File: tb/tb_multiplexer_2_block.sv
// Scoreboard bench for multiplexer_2_block: expected results queued at drive time,
// popped and compared when out_valid is seen.
module tb_multiplexer_2_block;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] r;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];
    logic [W-1:0] last_d;
    logic [W-1:0] last_r;
    logic         err_m;

    multiplexer_2_block_if #(.WIDTH(W)) io ();

    multiplexer_2_block #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref3(input logic [1:0] s, input logic [W-1:0] o1,
                                          input logic [W-1:0] o2, input logic [W-1:0] o3);
        if (s == 2'd0) return o1;
        if (s == 2'd1) return o2;
        if (s == 2'd2) return o3;
        return '0;
    endfunction

    task automatic set_inputs(input logic v, input logic sl, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [1:0] s, input logic [W-1:0] o1,
                              input logic [W-1:0] o2, input logic [W-1:0] o3);
        exp_t e;
        io.in_valid      = v;
        io.select_line   = sl;
        io.input_a       = a;
        io.input_b       = b;
        io.selection     = s;
        io.input_option1 = o1;
        io.input_option2 = o2;
        io.input_option3 = o3;
        if (v) begin
            e.d = sl ? b : a;
            e.r = ref3(s, o1, o2, o3);
            sb_q.push_back(e);
`ifdef MULTIPLEXER_SEL_ERR_EN
            if (s == 2'd3) err_m = 1'b1;
`endif
        end
    endtask

    task automatic observe(input string tag);
        exp_t e;
        check_val({tag, ".vld"}, {31'd0, io.out_valid}, {31'd0, (sb_q.size() > 0)});
        if (io.out_valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            last_d = e.d;
            last_r = e.r;
        end
        sb_q.delete();
        check_val({tag, ".data"}, io.output_data, last_d);
        check_val({tag, ".result"}, io.output_result, last_r);
        check_val({tag, ".err"}, {31'd0, io.sel_error}, {31'd0, err_m});
    endtask

    task automatic cycle(input string tag, input logic v, input logic sl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] s, input logic [W-1:0] o1,
                         input logic [W-1:0] o2, input logic [W-1:0] o3);
        @(negedge clk);
        set_inputs(v, sl, a, b, s, o1, o2, o3);
        @(posedge clk);
        #1;
        observe(tag);
    endtask

    task automatic rand_cycle(input string tag, input logic v);
        cycle(tag, v, 1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 2)),
              $urandom, $urandom, $urandom);
    endtask

    task automatic check_reset_zero(input string tag);
        check_val({tag, ".data"}, io.output_data, '0);
        check_val({tag, ".result"}, io.output_result, '0);
        check_val({tag, ".vld"}, {31'd0, io.out_valid}, '0);
        check_val({tag, ".err"}, {31'd0, io.sel_error}, '0);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        last_d = '0;
        last_r = '0;
        err_m  = 1'b0;
        rst    = 1'b0;
        set_inputs(1'b1, 1'b1, $urandom, $urandom, 2'd3, $urandom, $urandom, $urandom);
        sb_q.delete();
        err_m = 1'b0;

        // Asynchronous reset takes effect before the first clock edge at t=5.
        #2 rst = 1'b1;
        #1 check_reset_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 check_reset_zero("rst_held");
        @(negedge clk);
        set_inputs(1'b0, 1'b0, '0, '0, 2'd0, '0, '0, '0);
        rst = 1'b0;
        @(posedge clk);
        #1 observe("idle0");

        cycle("a10", 1'b1, 1'b0, 32'd10, 32'd20, 2'd2, 32'd30, 32'd40, 32'd50);
        check_val("a10.abs_data", io.output_data, 32'd10);
        check_val("a10.abs_res", io.output_result, 32'd50);
        cycle("b20", 1'b1, 1'b1, 32'd10, 32'd20, 2'd0, 32'd30, 32'd40, 32'd50);
        check_val("b20.abs_data", io.output_data, 32'd20);
        check_val("b20.abs_res", io.output_result, 32'd30);
        cycle("opt2", 1'b1, 1'b0, 32'd10, 32'd20, 2'd1, 32'd30, 32'd40, 32'd50);
        check_val("opt2.abs_res", io.output_result, 32'd40);

        cycle("hold1", 1'b0, 1'b1, 32'd99, 32'd98, 2'd3, 32'd97, 32'd96, 32'd95);
        cycle("hold2", 1'b0, 1'b0, 32'd1, 32'd2, 2'd2, 32'd3, 32'd4, 32'd5);
        check_val("hold.abs_data", io.output_data, 32'd10);

        cycle("sel3", 1'b1, 1'b1, 32'h1234, 32'h5678, 2'd3, 32'd7, 32'd8, 32'd9);
        check_val("sel3.abs_res", io.output_result, 32'd0);
        check_val("sel3.abs_data", io.output_data, 32'h5678);
        cycle("sticky1", 1'b1, 1'b0, 32'd11, 32'd12, 2'd0, 32'd13, 32'd14, 32'd15);
        cycle("sticky2", 1'b0, 1'b0, '0, '0, 2'd0, '0, '0, '0);

        for (int i = 0; i < 8; i++) rand_cycle($sformatf("stream%0d", i), 1'b1);

        // A pending sample is launched, then reset arrives before its capture edge.
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 32'hdead, 32'hbeef, 2'd3, 32'd1, 32'd2, 32'd3);
        #2 rst = 1'b1;
        #1 check_reset_zero("rst_mid");
        sb_q.delete();
        last_d = '0;
        last_r = '0;
        err_m  = 1'b0;
        @(posedge clk);
        #1 check_reset_zero("rst_mid_edge");
        @(negedge clk);
        set_inputs(1'b0, 1'b0, '0, '0, 2'd0, '0, '0, '0);
        rst = 1'b0;
        @(posedge clk);
        #1 observe("post_rst_idle");
        cycle("post_rst_idle2", 1'b0, 1'b1, 32'd5, 32'd6, 2'd1, 32'd7, 32'd8, 32'd9);

        cycle("post_rst_s", 1'b1, 1'b1, 32'd5, 32'd6, 2'd1, 32'd7, 32'd8, 32'd9);
        check_val("post_rst.abs_data", io.output_data, 32'd6);
        check_val("post_rst.abs_res", io.output_result, 32'd8);
        cycle("tail", 1'b0, 1'b0, '0, '0, 2'd0, '0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
